// File: rtl/prelude_pkg.sv
// Shared constants and state encodings for the program loader and its UART receiver.
package prelude_pkg;

    localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        WAIT_SYNC,
        GET_LEN,
        GET_DATA,
        GET_SUM,
        RUN,
        ERROR
    } loader_state_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Instruction-memory write port and core-control outputs of the program loader.
interface prog_loader_if;

    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_reset;
    logic       load_done;
    logic       load_err;

    modport master (
        output mem_we, mem_addr, mem_wdata, cpu_reset, load_done, load_err
    );

    modport slave (
        input mem_we, mem_addr, mem_wdata, cpu_reset, load_done, load_err
    );

endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the line, samples mid-bit, reports good
// bytes, framing errors and breaks as single-cycle pulses.
module uart_rx
    import prelude_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_line,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_ferr,
    output logic       rx_brk
);

    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    rx_state_t              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             byte_q, byte_d;
    logic                   hold_q, hold_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   brk_q, brk_d;
    logic                   line;

    assign line = sync_q[SYNC_STAGES-1];

    // Next-state logic for the synchronizer and the bit-sampling FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        sync_d  = {sync_q[SYNC_STAGES-2:0], rx_line};
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        hold_d  = hold_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        brk_d   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!line) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    bit_d = 3'd0;
                    // A start bit that is gone by mid-bit is a glitch.
                    state_d = line ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {line, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (hold_q) begin
                    // After a bad stop bit, only a high line can end the frame.
                    if (line) begin
                        hold_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else if (cnt_q == BIT_LAST) begin
                    cnt_d  = '0;
                    byte_d = shift_q;
                    if (line) begin
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d = 1'b1;
                        brk_d  = (shift_q == 8'h00);
                        hold_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; the synchronizer resets to the idle-high line level.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so every flop samples values from before this edge.
        if (reset) begin
            sync_q  <= '1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            hold_q  <= 1'b0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            brk_q   <= brk_d;
        end
    end

    assign rx_byte  = byte_q;
    assign rx_valid = valid_q;
    assign rx_ferr  = ferr_q;
    assign rx_brk   = brk_q;

endmodule

// File: rtl/prog_loader.sv
// Serial boot loader: receives A5/LEN/data[/CHK] over UART, writes the image
// into instruction memory and holds the core in reset until a good load.
// Optional macro PROG_LOADER_CHECKSUM_EN adds the trailing checksum byte check.
module prog_loader
    import prelude_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234,
    parameter int SYNC_STAGES  = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          uart_rx,
    prog_loader_if.master bus
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ferr;
    logic       rx_brk;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clk     (clk),
        .reset   (reset),
        .rx_line (uart_rx),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid),
        .rx_ferr (rx_ferr),
        .rx_brk  (rx_brk)
    );

    loader_state_t state_q, state_d;
    logic [8:0]    rem_q, rem_d;      // bytes still to write; 256 encodes LEN=0
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    sum_q, sum_d;
    logic          we_q, we_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          cpu_reset_q, cpu_reset_d;
    logic          load_done_q, load_done_d;
    logic          load_err_q, load_err_d;

    // Loader protocol FSM; outputs are decoded from the next state so they register with it.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        sum_d   = sum_q;
        we_d    = 1'b0;
        wdata_d = wdata_q;

        // Address/sum/count advance in the cycle the strobe is high.
        if (we_q) begin
            addr_d = addr_q + 8'd1;
            sum_d  = sum_q + wdata_q;
            rem_d  = rem_q - 9'd1;
        end

        case (state_q)
            WAIT_SYNC: begin
                if (rx_valid && rx_byte == LOADER_SYNC_BYTE) state_d = GET_LEN;
            end
            GET_LEN: begin
                if (rx_ferr) begin
                    state_d = ERROR;
                end else if (rx_valid) begin
                    rem_d   = (rx_byte == 8'h00) ? 9'd256 : {1'b0, rx_byte};
                    addr_d  = 8'h00;
                    sum_d   = 8'h00;
                    state_d = GET_DATA;
                end
            end
            GET_DATA: begin
                if (rx_ferr) begin
                    state_d = ERROR;
                end else if (rx_valid) begin
                    we_d    = 1'b1;
                    wdata_d = rx_byte;
                end else if (we_q && rem_q == 9'd1) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_d = GET_SUM;
`else
                    state_d = RUN;
`endif
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            GET_SUM: begin
                if (rx_ferr) begin
                    state_d = ERROR;
                end else if (rx_valid) begin
                    state_d = (rx_byte == sum_q) ? RUN : ERROR;
                end
            end
`endif
            RUN: begin
                if (rx_brk) state_d = WAIT_SYNC;
            end
            ERROR: begin
                if (rx_valid && rx_byte == LOADER_SYNC_BYTE) state_d = GET_LEN;
            end
            default: state_d = WAIT_SYNC;
        endcase

        cpu_reset_d = (state_d != RUN);
        load_done_d = (state_d == RUN);
        load_err_d  = (state_d == ERROR);
    end

    // Loader registers; reset holds the core in reset and parks the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= WAIT_SYNC;
            rem_q       <= '0;
            addr_q      <= '0;
            sum_q       <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            cpu_reset_q <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            addr_q      <= addr_d;
            sum_q       <= sum_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            cpu_reset_q <= cpu_reset_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_reset = cpu_reset_q;
    assign bus.load_done = load_done_q;
    assign bus.load_err  = load_err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed table, multi-cycle corner
// sequences and randomized image loads against a whole-image reference model.
module tb_prog_loader;

    localparam int CPB   = 8;
    localparam int FRAME = 10 * CPB;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic uart_rx = 1'b1;

    prog_loader_if bus ();

    prog_loader #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (2)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .uart_rx(uart_rx),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Write log captured from the memory port.
    logic [7:0] wr_addr[$];
    logic [7:0] wr_data[$];
    int         wr_cyc[$];
    logic [7:0] exp_wr[$];
    int         cyc      = 0;
    int         fall_cyc = -1;
    int         dbl_we   = 0;
    int         rxv_cnt  = 0;

    initial begin : monitor
        logic prev_we;
        logic prev_cr;
        prev_we = 1'b0;
        prev_cr = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.mem_we) begin
                wr_addr.push_back(bus.mem_addr);
                wr_data.push_back(bus.mem_wdata);
                wr_cyc.push_back(cyc);
                if (prev_we) dbl_we++;
            end
            if (prev_cr && !bus.cpu_reset) fall_cyc = cyc;
            if (dut.u_rx.rx_valid) rxv_cnt++;
            prev_we = bus.mem_we;
            prev_cr = bus.cpu_reset;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        exp_wr.delete();
        fall_cyc = -1;
    endtask

    task automatic do_reset();
        uart_rx = 1'b1;
        reset   = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        clear_log();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b1);
    endtask

    task automatic send_break();
        uart_rx = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic settle();
        repeat (3 * CPB) @(negedge clk);
    endtask

    task automatic check_status(input string tag, input logic run, input logic err);
        check({tag, " cpu_reset"}, bus.cpu_reset, !run);
        check({tag, " load_done"}, bus.load_done, run);
        check({tag, " load_err"}, bus.load_err, err);
    endtask

    // Expected writes: exp_wr[i] at address i (mod 256), in order.
    task automatic check_writes(input string tag);
        int bad;
        bad = 0;
        check({tag, " write count"}, wr_data.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size(); i++) begin
            if (i >= wr_data.size()) bad++;
            else if (wr_data[i] !== exp_wr[i] || wr_addr[i] !== 8'(i)) bad++;
        end
        check({tag, " write contents"}, bad, 0);
    endtask

    typedef struct packed {
        logic        rst_first;
        logic [3:0]  n;          // bytes sent, first byte in b[63:56]
        logic [63:0] b;
        logic [2:0]  nw;         // writes expected, first in wd[31:24]
        logic [31:0] wd;
        logic [7:0]  end_addr;
        logic        run;
        logic        err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [7:0] img[$];
        logic [7:0] sum;
        logic       cur_run;
        logic       bad;
        int         len;
        int         rxv0;

        vecs[0] = '{1'b1, 4'd6, 64'hA5031122_33660000, 3'd3, 32'h11223300, 8'd3, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 4'd5, 64'hA5021020_00000000, 3'd2, 32'h10200000, 8'd2, !CHK_EN, CHK_EN};
        vecs[2] = '{1'b0, 4'd4, 64'hA5017F7F_00000000, CHK_EN ? 3'd1 : 3'd0, 32'h7F000000,
                    CHK_EN ? 8'd1 : 8'd2, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 4'd6, 64'h553CA501_05050000, 3'd1, 32'h05000000, 8'd1, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 4'd4, 64'hA501AAAB_00000000, 3'd1, 32'hAA000000, 8'd1, !CHK_EN, CHK_EN};

        do_reset();
        check("reset mem_we", bus.mem_we, 1'b0);
        check("reset mem_addr", bus.mem_addr, 8'h00);
        check("reset mem_wdata", bus.mem_wdata, 8'h00);
        check_status("reset", 1'b0, 1'b0);

        // Directed table.
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].rst_first) do_reset();
            clear_log();
            for (int i = 0; i < int'(vecs[v].n); i++) send_byte(vecs[v].b[63 - 8 * i -: 8]);
            settle();
            for (int i = 0; i < int'(vecs[v].nw); i++) exp_wr.push_back(vecs[v].wd[31 - 8 * i -: 8]);
            check_writes($sformatf("vec%0d", v));
            check($sformatf("vec%0d mem_addr", v), bus.mem_addr, vecs[v].end_addr);
            check_status($sformatf("vec%0d", v), vecs[v].run, vecs[v].err);
        end

        // Strobe spacing and cpu_reset release timing on back-to-back frames.
        do_reset();
        send_byte(8'hA5); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h66);
        settle();
        check("write spacing", (wr_cyc.size() == 3) ? wr_cyc[1] - wr_cyc[0] : -1, FRAME);
        check("release delay", (wr_cyc.size() == 3) ? fall_cyc - wr_cyc[2] : -1, CHK_EN ? FRAME : 1);
        check("no double strobe", dbl_we, 0);

        // Break while running returns to WAIT_SYNC with the core held; then reload.
        clear_log();
        send_break();
        check_status("after break", 1'b0, 1'b0);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h42); send_byte(8'h42);
        settle();
        exp_wr.push_back(8'h42);
        check_writes("post-break load");
        check_status("post-break load", 1'b1, 1'b0);

        // Short low glitch in IDLE must not produce a byte.
        do_reset();
        rxv0 = rxv_cnt;
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("glitch rx_valid", rxv_cnt - rxv0, 0);
        check_status("glitch", 1'b0, 1'b0);

        // Framing error mid-data: error, earlier writes stay.
        do_reset();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
        send_frame(8'h33, 1'b0);
        settle();
        exp_wr.push_back(8'h11);
        check_writes("ferr");
        check("ferr mem_addr", bus.mem_addr, 8'd1);
        check_status("ferr", 1'b0, 1'b1);

        // Full 256-byte image with LEN=0; address wraps to 0.
        do_reset();
        send_byte(8'hA5); send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i));
            exp_wr.push_back(8'(i));
        end
        if (CHK_EN) send_byte(8'h80);
        settle();
        check_writes("len256");
        check("len256 mem_addr", bus.mem_addr, 8'h00);
        check_status("len256", 1'b1, 1'b0);

        // Asynchronous reset partway through a load.
        do_reset();
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
        uart_rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midreset mem_we", bus.mem_we, 1'b0);
        check("midreset mem_addr", bus.mem_addr, 8'h00);
        check("midreset mem_wdata", bus.mem_wdata, 8'h00);
        check_status("midreset", 1'b0, 1'b0);
        uart_rx = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        clear_log();
        send_byte(8'hA5); send_byte(8'h04);
        for (int i = 1; i <= 4; i++) begin
            send_byte(8'(i));
            exp_wr.push_back(8'(i));
        end
        if (CHK_EN) send_byte(8'h0A);
        settle();
        check_writes("after midreset");
        check_status("after midreset", 1'b1, 1'b0);

        // Randomized loads checked against the whole-image model.
        do_reset();
        cur_run = 1'b0;
        for (int it = 0; it < 20; it++) begin
            if (cur_run) send_break();
            clear_log();
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                logic [7:0] nb;
                nb = 8'($urandom);
                if (nb == 8'hA5) nb = 8'h5A;
                send_byte(nb);
            end
            len = int'($urandom_range(1, 10));
            img.delete();
            sum = 8'h00;
            for (int i = 0; i < len; i++) begin
                img.push_back(8'($urandom));
                sum += img[i];
            end
            bad = CHK_EN && ($urandom_range(0, 3) == 0);
            send_byte(8'hA5);
            send_byte(8'(len));
            foreach (img[i]) begin
                send_byte(img[i]);
                exp_wr.push_back(img[i]);
            end
            if (CHK_EN) send_byte(bad ? (sum ^ (8'h01 << $urandom_range(0, 7))) : sum);
            settle();
            check_writes($sformatf("rand%0d", it));
            check($sformatf("rand%0d mem_addr", it), bus.mem_addr, 8'(len));
            check_status($sformatf("rand%0d", it), !bad, bad);
            cur_run = !bad;
        end

        check("no double strobe overall", dbl_we, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
